// File: rtl/usb_serial_port_if.sv
// usb_serial_port_if: load/store path between the address decoder and the USB UART.
interface usb_serial_port_if;
    logic [1:0] memRW;
    logic [2:0] index;
    logic [7:0] wrData;
    logic [7:0] rxData;
    logic [1:0] state;
    modport master(output memRW, index, wrData, input rxData, state);
    modport slave(input memRW, index, wrData, output rxData, state);
endinterface

// File: rtl/usb_serial_port.sv
// usb_serial_port: memory-mapped 8N1 UART (data/status registers) for the USB serial bridge.
module usb_serial_port #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [2:0]  IDX_DATA     = 3'b110,
    parameter logic [2:0]  IDX_STATE    = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    usb_serial_port_if.slave  bus,
    input  logic              u_txd,
    output logic              u_rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

    logic [4:0] acc_q;
    logic hit, new_acc, wr_new, rd_new;
    st_t tx_st, tx_nx, rx_st, rx_nx;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0] tx_bit, rx_bit;
    logic [7:0] tx_byte, rx_sh, rx_q;
    logic [1:0] sync;
    logic txd_nx, tx_last, rx_last, rx_half, rx_line, rx_hold, avail, rx_done, rx_ferr;

    // Only the first cycle of a held {memRW, index} code counts as an access
    assign hit = bus.index == IDX_DATA && IDX_DATA != IDX_STATE;
    assign new_acc = {bus.memRW, bus.index} != acc_q;
    assign wr_new = new_acc && hit && bus.memRW == 2'b10;
    assign rd_new = new_acc && hit && bus.memRW == 2'b01;

    assign tx_last = tx_cnt == LAST;
    assign rx_last = rx_cnt == LAST;
    assign rx_half = rx_cnt == HALF;
    assign rx_line = sync[1];
    assign rx_done = rx_st == STOP && rx_last && rx_line;
    assign rx_ferr = rx_st == STOP && rx_last && !rx_line;

    assign bus.rxData = rx_q;
    assign bus.state = {avail, tx_st == IDLE};

    always_comb begin
        tx_nx = tx_st;
        txd_nx = 1'b1;
        case (tx_st)
            IDLE: begin
                tx_nx = wr_new ? START : IDLE;
                txd_nx = !wr_new;
            end
            START: begin
                tx_nx = tx_last ? DATA : START;
                txd_nx = tx_last ? tx_byte[0] : 1'b0;
            end
            DATA: begin
                tx_nx = tx_last && tx_bit == 3'd7 ? STOP : DATA;
                txd_nx = tx_last ? (tx_bit == 3'd7 ? 1'b1 : tx_byte[tx_bit + 3'd1]) : tx_byte[tx_bit];
            end
            default: tx_nx = tx_last ? IDLE : STOP;
        endcase
    end

    // After a framing error rx_hold blocks new starts until the line idles high
    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            IDLE:    rx_nx = !rx_line && !rx_hold ? START : IDLE;
            START:   rx_nx = rx_half ? (rx_line ? IDLE : DATA) : START;
            DATA:    rx_nx = rx_last && rx_bit == 3'd7 ? STOP : DATA;
            default: rx_nx = rx_last ? IDLE : STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            tx_st <= IDLE;
            u_rxd <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_byte <= '0;
            sync <= 2'b11;
            rx_st <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            rx_hold <= 1'b0;
            rx_q <= '0;
            avail <= 1'b0;
        end else begin
            acc_q <= {bus.memRW, bus.index};
            tx_st <= tx_nx;
            u_rxd <= txd_nx;
            tx_cnt <= tx_st == IDLE || tx_last ? '0 : tx_cnt + 1'b1;
            tx_bit <= tx_st == DATA && tx_last ? tx_bit + 3'd1 : tx_bit;
            tx_byte <= tx_st == IDLE && wr_new ? bus.wrData : tx_byte;
            sync <= {sync[0], u_txd};
            rx_st <= rx_nx;
            rx_cnt <= rx_st == IDLE || (rx_st == START && rx_half) || rx_last ? '0 : rx_cnt + 1'b1;
            rx_bit <= rx_st == DATA && rx_last ? rx_bit + 3'd1 : rx_bit;
            rx_sh <= rx_st == DATA && rx_last ? {rx_line, rx_sh[7:1]} : rx_sh;
            rx_hold <= rx_ferr ? 1'b1 : (rx_line ? 1'b0 : rx_hold);
            rx_q <= rx_done ? rx_sh : rx_q;
            avail <= rx_done ? 1'b1 : (rd_new ? 1'b0 : avail);
        end
    end
endmodule

// File: tb/tb_usb_serial_port.sv
// tb_usb_serial_port: randomized self-checking bench for the USB serial UART against a frame-level model.
module tb_usb_serial_port;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic u_txd = 1'b1;
    logic u_rxd;
    int checks = 0;
    int errors = 0;
    int lat = -1;
    logic [7:0] exp_data = 8'h00;
    logic exp_avail = 1'b0;

    usb_serial_port_if bus();

    usb_serial_port #(.CLKS_PER_BIT(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .u_txd(u_txd),
        .u_rxd(u_rxd)
    );

    always #5 clk = ~clk;

    // Drive one 8N1 frame on u_txd; each bit held N cycles
    task automatic send_uart(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int p = 0; p < 10; p++) begin
            @(posedge clk); #1 u_txd = f[p];
            repeat (N - 1) @(posedge clk);
        end
        @(posedge clk); #1 u_txd = 1'b1;
    endtask

    task automatic read_pulse();
        @(posedge clk); #1 bus.memRW = 2'b01; bus.index = 3'b110;
        @(posedge clk); #1 bus.memRW = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (u_rxd !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", u_rxd); end
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL reset_state: got %b expected 01", bus.state); end
        checks++; if (bus.rxData !== 8'h00) begin errors++; $display("FAIL reset_rxdata: got %h expected 00", bus.rxData); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.state !== 2'b01 || u_rxd !== 1'b1) begin errors++; $display("FAIL reset_release: got state=%b line=%b expected 01/1", bus.state, u_rxd); end
    endtask

    task automatic test_tx();
        logic [7:0] b;
        logic [9:0] f;
        logic el;
        for (int k = 0; k < 5; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom);
            f = {1'b1, b, 1'b0};
            @(posedge clk); #1 bus.memRW = 2'b10; bus.index = 3'b110; bus.wrData = b;
            for (int c = 0; c <= 80; c++) begin
                @(posedge clk); #1;
                if (c == 0) bus.memRW = 2'b00;
                el = (c < 80) ? f[c / 8] : 1'b1;
                checks++; if (u_rxd !== el) begin errors++; $display("FAIL tx_line byte=%h cycle=%0d: got %b expected %b", b, c, u_rxd, el); end
                checks++; if (bus.state[0] !== (c >= 80)) begin errors++; $display("FAIL tx_ready byte=%h cycle=%0d: got %b expected %b", b, c, bus.state[0], c >= 80); end
            end
        end
    endtask

    task automatic test_state_write();
        @(posedge clk); #1 bus.memRW = 2'b10; bus.index = 3'b111; bus.wrData = 8'($urandom);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 2) bus.memRW = 2'b00;
            checks++; if (u_rxd !== 1'b1 || bus.state[0] !== 1'b1) begin errors++; $display("FAIL state_write cycle=%0d: got line=%b ready=%b expected 1/1", c, u_rxd, bus.state[0]); end
        end
    endtask

    task automatic test_busy_write();
        logic [9:0] f;
        logic el;
        f = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1 bus.memRW = 2'b10; bus.index = 3'b110; bus.wrData = 8'hA5;
        for (int c = 0; c <= 120; c++) begin
            @(posedge clk); #1;
            if (c == 0) bus.memRW = 2'b00;
            if (c == 20) begin bus.memRW = 2'b10; bus.wrData = 8'h3C; end
            if (c == 23) bus.memRW = 2'b00;
            el = (c < 80) ? f[c / 8] : 1'b1;
            checks++; if (u_rxd !== el) begin errors++; $display("FAIL busy_line cycle=%0d: got %b expected %b", c, u_rxd, el); end
            checks++; if (bus.state[0] !== (c >= 80)) begin errors++; $display("FAIL busy_ready cycle=%0d: got %b expected %b", c, bus.state[0], c >= 80); end
        end
    endtask

    task automatic test_rx();
        logic [7:0] b;
        send_uart(8'h5A, 1'b1);
        exp_data = 8'h5A; exp_avail = 1'b1;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_5a: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        @(posedge clk); #1 bus.memRW = 2'b01; bus.index = 3'b110;
        repeat (4) @(posedge clk);
        #1 bus.memRW = 2'b00;
        exp_avail = 1'b0;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_read_hold: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send_uart(b, 1'b1);
            exp_data = b; exp_avail = 1'b1;
            checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_rand%0d: got %h/%b expected %h/%b", k, bus.rxData, bus.state[1], exp_data, exp_avail); end
            if ($urandom_range(1) == 1) begin
                read_pulse();
                exp_avail = 1'b0;
                checks++; if (bus.state[1] !== exp_avail || bus.rxData !== exp_data) begin errors++; $display("FAIL rx_clear%0d: got %h/%b expected %h/%b", k, bus.rxData, bus.state[1], exp_data, exp_avail); end
            end
        end
        @(posedge clk); #1 bus.memRW = 2'b01; bus.index = 3'b110;
        b = 8'($urandom);
        send_uart(b, 1'b1);
        exp_data = b; exp_avail = 1'b1;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_held_read: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        @(posedge clk); #1 bus.memRW = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_held_release: got %b expected %b", bus.state[1], exp_avail); end
    endtask

    task automatic test_rx_errors();
        logic [7:0] b;
        read_pulse();
        exp_avail = 1'b0;
        @(posedge clk); #1 u_txd = 1'b0;
        repeat (2) @(posedge clk);
        #1 u_txd = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_glitch: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        b = 8'($urandom);
        send_uart(b, 1'b0);
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_framing: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        repeat (4) @(posedge clk);
        send_uart(8'h11, 1'b1);
        exp_data = 8'h11; exp_avail = 1'b1;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL rx_after_framing: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        send_uart(8'h01, 1'b1);
        send_uart(8'h02, 1'b1);
        exp_data = 8'h02; exp_avail = 1'b1;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL overrun: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        read_pulse();
        exp_avail = 1'b0;
        b = 8'($urandom);
        fork
            send_uart(b, 1'b1);
            begin
                lat = -1;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk); #1;
                    if (bus.state[1] && lat < 0) lat = i;
                end
            end
        join
        exp_data = b; exp_avail = 1'b1;
        checks++; if (lat < 9 * N + N / 2 || lat > 10 * N + 2) begin errors++; $display("FAIL rx_latency: got %0d expected within stop bit", lat); lat = 10 * N - 1; end
        checks++; if (bus.rxData !== exp_data) begin errors++; $display("FAIL rx_timed: got %h expected %h", bus.rxData, exp_data); end
        read_pulse();
        exp_avail = 1'b0;
        fork
            send_uart(8'h03, 1'b1);
            begin
                repeat (lat) @(posedge clk);
                #1 bus.memRW = 2'b01; bus.index = 3'b110;
                @(posedge clk); #1 bus.memRW = 2'b00;
            end
        join
        exp_data = 8'h03; exp_avail = 1'b1;
        checks++; if (bus.rxData !== exp_data || bus.state[1] !== exp_avail) begin errors++; $display("FAIL collision: got %h/%b expected %h/%b", bus.rxData, bus.state[1], exp_data, exp_avail); end
        read_pulse();
        exp_avail = 1'b0;
        checks++; if (bus.state[1] !== exp_avail) begin errors++; $display("FAIL collision_clear: got %b expected %b", bus.state[1], exp_avail); end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1 bus.memRW = 2'b10; bus.index = 3'b110; bus.wrData = 8'h00;
        @(posedge clk); #1 bus.memRW = 2'b00;
        repeat (30) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        exp_data = 8'h00; exp_avail = 1'b0;
        checks++; if (u_rxd !== 1'b1) begin errors++; $display("FAIL midreset_line: got %b expected 1", u_rxd); end
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL midreset_state: got %b expected 01", bus.state); end
        checks++; if (bus.rxData !== exp_data) begin errors++; $display("FAIL midreset_rxdata: got %h expected %h", bus.rxData, exp_data); end
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++; if (u_rxd !== 1'b1 || bus.state !== 2'b01) begin errors++; $display("FAIL midreset_after cycle=%0d: got line=%b state=%b expected 1/01", c, u_rxd, bus.state); end
        end
    endtask

    initial begin
        bus.memRW = 2'b00;
        bus.index = 3'b000;
        bus.wrData = 8'h00;
        test_reset();
        test_tx();
        test_state_write();
        test_busy_write();
        test_rx();
        test_rx_errors();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
